// File: rtl/tape_ctrl.sv
// tape_ctrl: CAS player transport FSM turning image, OSD and motor events into play/rewind/LED.
module tape_ctrl #(
  parameter int MOTOR_OFF_DLY = 26850,
  parameter int REWIND_LEN    = 4,
  parameter int BLINK_BIT     = 20
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ce_5m3,
  input  logic       img_loaded,
  input  logic       img_new,
  input  logic       btn_play,
  input  logic       btn_rewind,
  input  logic       motor,
  output logic       play,
  output logic       rewind,
  output logic       led,
  output logic [2:0] state_o
);
  typedef enum logic [2:0] {
    EMPTY   = 3'd0,
    REWIND  = 3'd1,
    STOPPED = 3'd2,
    PLAYING = 3'd3,
    HOLD    = 3'd4,
    PAUSED  = 3'd5
  } state_t;
  state_t             state_q, state_d;
  logic [15:0]        hold_cnt_q, hold_cnt_d;
  logic [7:0]         rew_cnt_q, rew_cnt_d;
  logic [BLINK_BIT:0] tick_cnt_q, tick_cnt_d;
  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    rew_cnt_d  = rew_cnt_q;
    tick_cnt_d = tick_cnt_q + {{BLINK_BIT{1'b0}}, ce_5m3};
    if (!img_loaded) state_d = EMPTY;
    else if (img_new || (btn_rewind && state_q != EMPTY)) begin
      state_d   = REWIND;
      rew_cnt_d = 8'(REWIND_LEN - 1);
    end else begin
      case (state_q)
        REWIND: begin
          state_d   = (rew_cnt_q == '0) ? STOPPED : REWIND;
          rew_cnt_d = (rew_cnt_q == '0) ? rew_cnt_q : rew_cnt_q - 8'd1;
        end
        STOPPED: state_d = btn_play ? PAUSED : motor ? PLAYING : STOPPED;
        PLAYING: begin
          state_d    = btn_play ? PAUSED : motor ? PLAYING : HOLD;
          hold_cnt_d = 16'(MOTOR_OFF_DLY - 1);
        end
        // motor return beats a coincident tick; the hold count is simply abandoned
        HOLD: begin
          state_d    = btn_play ? PAUSED : motor ? PLAYING :
                       (ce_5m3 && hold_cnt_q == '0) ? STOPPED : HOLD;
          hold_cnt_d = (ce_5m3 && hold_cnt_q != '0) ? hold_cnt_q - 16'd1 : hold_cnt_q;
        end
        PAUSED: state_d = !btn_play ? PAUSED : motor ? PLAYING : STOPPED;
        default: state_d = state_q;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= EMPTY;
      hold_cnt_q <= '0;
      rew_cnt_q  <= '0;
      tick_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      rew_cnt_q  <= rew_cnt_d;
      tick_cnt_q <= tick_cnt_d;
    end
  end
  assign play    = (state_q == PLAYING) || (state_q == HOLD);
  assign rewind  = (state_q == REWIND);
  assign led     = play || ((state_q == PAUSED) && tick_cnt_q[BLINK_BIT]);
  assign state_o = state_q;
endmodule
